// File: rtl/multi_digit_scoreboard.sv
// BCD scoreboard with debounced +1/+10/-1 buttons and a hold-to-clear button.
// Optional decrement path is built only when SCOREBOARD_DEC_EN is defined.
module multi_digit_scoreboard #(
  parameter int unsigned NUM_DIGITS      = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 100000000,
  parameter int unsigned WRAP            = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc1_btn_n,
  input  logic                    inc10_btn_n,
  input  logic                    dec1_btn_n,
  input  logic                    reset_btn_n,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    overflow
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [4*NUM_DIGITS-1:0] MAX_BCD = {NUM_DIGITS{4'h9}};

  // Channel order: 0 inc1, 1 inc10, 2 reset, 3 dec (when built).
`ifdef SCOREBOARD_DEC_EN
  localparam int unsigned NB = 4;
  logic [NB-1:0] btn_raw;
  assign btn_raw = {dec1_btn_n, reset_btn_n, inc10_btn_n, inc1_btn_n};
`else
  localparam int unsigned NB = 3;
  logic [NB-1:0] btn_raw;
  logic          unused_dec;
  assign btn_raw    = {reset_btn_n, inc10_btn_n, inc1_btn_n};
  assign unused_dec = dec1_btn_n;
`endif

  logic [NB-1:0] sync1_q, sync2_q, acc_q, acc_prev_q, fall;
  logic [DW-1:0] db_cnt_q [NB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      acc_q      <= '1;
      acc_prev_q <= '1;
      for (int i = 0; i < int'(NB); i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      acc_prev_q <= acc_q;
      for (int i = 0; i < int'(NB); i++) begin
        if (sync2_q[i] == acc_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          acc_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign fall = acc_prev_q & ~acc_q;

  logic inc1_q, inc10_q, dec_q, clr_q, hold_done_q, unused_fall;
  logic [HW-1:0] hold_cnt_q;

  // The reset channel is level-driven, so its edge is not needed.
  assign unused_fall = fall[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc1_q      <= 1'b0;
      inc10_q     <= 1'b0;
      clr_q       <= 1'b0;
      hold_done_q <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      inc1_q  <= fall[0];
      inc10_q <= fall[1];
      clr_q   <= 1'b0;
      if (acc_q[2]) begin
        hold_cnt_q  <= '0;
        hold_done_q <= 1'b0;
      end else if (!hold_done_q) begin
        if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
          clr_q       <= 1'b1;
          hold_done_q <= 1'b1;
          hold_cnt_q  <= '0;
        end else begin
          hold_cnt_q <= hold_cnt_q + 1'b1;
        end
      end
    end
  end

`ifdef SCOREBOARD_DEC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dec_q <= 1'b0;
    else        dec_q <= fall[3];
  end
`else
  assign dec_q = 1'b0;
`endif

  logic [4*NUM_DIGITS-1:0] score_d;
  logic                    ovf_d;

  always_comb begin
    logic       carry;
    logic [4:0] sum;
    logic [3:0] dig;
    score_d = score_bcd;
    ovf_d   = overflow;
    carry   = 1'b0;
    sum     = '0;
    dig     = '0;
    if (clr_q) begin
      score_d = '0;
      ovf_d   = 1'b0;
    end else if (inc1_q || inc10_q) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        sum = {1'b0, score_bcd[4*i +: 4]} + {4'd0, carry};
        if (i == 0) sum = sum + {4'd0, inc1_q};
        if (i == 1) sum = sum + {4'd0, inc10_q};
        if (sum > 5'd9) begin
          score_d[4*i +: 4] = 4'(sum - 5'd10);
          carry             = 1'b1;
        end else begin
          score_d[4*i +: 4] = sum[3:0];
          carry             = 1'b0;
        end
      end
      if (carry) begin
        ovf_d = 1'b1;
        if (WRAP == 0) score_d = MAX_BCD;
      end
    end else if (dec_q) begin
      carry = 1'b1;  // borrow
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        dig = score_bcd[4*i +: 4];
        if (carry && dig == 4'd0) begin
          score_d[4*i +: 4] = 4'd9;
        end else begin
          score_d[4*i +: 4] = dig - {3'd0, carry};
          carry             = 1'b0;
        end
      end
      // A borrow out of the top digit leaves all nines, which is MAX for wrap mode.
      if (carry) begin
        ovf_d = 1'b1;
        if (WRAP == 0) score_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_bcd <= '0;
      overflow  <= 1'b0;
    end else begin
      score_bcd <= score_d;
      overflow  <= ovf_d;
    end
  end

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  endfunction

  always_comb begin
    logic lead;
    lead = 1'b1;
    hex  = '1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      if (score_bcd[4*i +: 4] != 4'd0) lead = 1'b0;
      hex[7*i +: 7] = (lead && i != 0) ? 7'h7F : seg(score_bcd[4*i +: 4]);
    end
  end

endmodule
